// File: rtl/csr_exec_unit_pkg.sv
// Shared definitions for the CSR execution unit: operation codes, CSR addresses,
// writable masks and the request FSM state type.
package csr_exec_unit_pkg;

    localparam int CSR_OP_WIDTH = 3;

    // Bit 2 selects the immediate operand form.
    localparam logic [CSR_OP_WIDTH-1:0] CSR_OP_NA    = 3'd0;
    localparam logic [CSR_OP_WIDTH-1:0] CSR_OP_CSRRW  = 3'd1;
    localparam logic [CSR_OP_WIDTH-1:0] CSR_OP_CSRRS  = 3'd2;
    localparam logic [CSR_OP_WIDTH-1:0] CSR_OP_CSRRC  = 3'd3;
    localparam logic [CSR_OP_WIDTH-1:0] CSR_OP_CSRRWI = 3'd5;
    localparam logic [CSR_OP_WIDTH-1:0] CSR_OP_CSRRSI = 3'd6;
    localparam logic [CSR_OP_WIDTH-1:0] CSR_OP_CSRRCI = 3'd7;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_TIME      = 12'hC01;
    localparam logic [11:0] CSR_INSTRET   = 12'hC02;
    localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [11:0] CSR_TIMEH     = 12'hC81;
    localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    localparam logic [31:0] MASK_MSTATUS = 32'h0000_1888;
    localparam logic [31:0] MASK_MIE     = 32'h0000_0888;
    localparam logic [31:0] MASK_MIP     = 32'h0000_0888;
    localparam logic [31:0] MASK_MTVEC   = 32'hFFFF_FFFC;
    localparam logic [31:0] MASK_MEPC    = 32'hFFFF_FFFE;
    localparam logic [31:0] MASK_ALL     = 32'hFFFF_FFFF;

    // mstatus.MPP comes out of reset as machine mode.
    localparam logic [31:0] MSTATUS_RESET = 32'h0000_1800;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } csr_state_e;

endpackage

// File: rtl/csr_exec_unit_counter64.sv
// 64-bit free-running counter with independently writable 32-bit halves.
// A write to either half suppresses that cycle's increment entirely, so no carry leaks.
module csr_counter64 (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inc,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wdata,
    output logic [63:0] value
);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            value <= '0;
        end else if (wr_lo) begin
            value[31:0] <= wdata;
        end else if (wr_hi) begin
            value[63:32] <= wdata;
        end else if (inc) begin
            value <= value + 64'd1;
        end
    end

endmodule

// File: rtl/csr_exec_unit.sv
// Machine-mode CSR execution unit: one request at a time through IDLE -> EXEC -> RESP,
// read-modify-write of the addressed CSR in EXEC, response strobe in RESP.
import csr_exec_unit_pkg::*;

module csr_exec_unit #(
    parameter logic [31:0] HART_ID = 32'd0
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    CSRwe,
    input  logic                    CSRre,
    input  logic [CSR_OP_WIDTH-1:0] CSRop,
    input  logic [11:0]             csr_addr,
    input  logic [31:0]             rs1_data,
    input  logic [4:0]              uimm,
    input  logic                    instret_inc,
    output logic [31:0]             rdata,
    output logic                    rdata_valid,
    output logic                    illegal
);

    csr_state_e state_q, state_d;
    logic accept;

    logic                    we_p0, re_p0;
    logic [CSR_OP_WIDTH-1:0] op_p0;
    logic [11:0]             addr_p0;
    logic [31:0]             rs1_p0;
    logic [4:0]              uimm_p0;

    logic [31:0] mstatus_q, mie_q, mip_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
    logic [63:0] mcycle, minstret;

    logic [31:0] old_val, src_val, new_val, wr_val, wr_mask;
    logic        known, read_only, op_ok, illegal_c, do_write;

    logic [31:0] rdata_p1;
    logic        illegal_p1;

    assign req_ready = (state_q == ST_IDLE);
    assign accept    = req_valid && req_ready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_EXEC;
            ST_EXEC: state_d = ST_RESP;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // ---- p0: request capture on acceptance ----
    always_ff @(posedge clk) begin
        if (accept) begin
            we_p0   <= CSRwe;
            re_p0   <= CSRre;
            op_p0   <= CSRop;
            addr_p0 <= csr_addr;
            rs1_p0  <= rs1_data;
            uimm_p0 <= uimm;
        end
    end

    always_comb begin
        old_val   = '0;
        wr_mask   = '0;
        known     = 1'b1;
        read_only = 1'b0;
        case (addr_p0)
            CSR_MSTATUS:   begin old_val = mstatus_q;       wr_mask = MASK_MSTATUS; end
            CSR_MIE:       begin old_val = mie_q;           wr_mask = MASK_MIE;     end
            CSR_MIP:       begin old_val = mip_q;           wr_mask = MASK_MIP;     end
            CSR_MTVEC:     begin old_val = mtvec_q;         wr_mask = MASK_MTVEC;   end
            CSR_MSCRATCH:  begin old_val = mscratch_q;      wr_mask = MASK_ALL;     end
            CSR_MEPC:      begin old_val = mepc_q;          wr_mask = MASK_MEPC;    end
            CSR_MCAUSE:    begin old_val = mcause_q;        wr_mask = MASK_ALL;     end
            CSR_MTVAL:     begin old_val = mtval_q;         wr_mask = MASK_ALL;     end
            CSR_MCYCLE:    begin old_val = mcycle[31:0];    wr_mask = MASK_ALL;     end
            CSR_MCYCLEH:   begin old_val = mcycle[63:32];   wr_mask = MASK_ALL;     end
            CSR_MINSTRET:  begin old_val = minstret[31:0];  wr_mask = MASK_ALL;     end
            CSR_MINSTRETH: begin old_val = minstret[63:32]; wr_mask = MASK_ALL;     end
            CSR_CYCLE, CSR_TIME:     begin old_val = mcycle[31:0];    read_only = 1'b1; end
            CSR_CYCLEH, CSR_TIMEH:   begin old_val = mcycle[63:32];   read_only = 1'b1; end
            CSR_INSTRET:   begin old_val = minstret[31:0];  read_only = 1'b1; end
            CSR_INSTRETH:  begin old_val = minstret[63:32]; read_only = 1'b1; end
            CSR_MHARTID:   begin old_val = HART_ID;         read_only = 1'b1; end
            default:       known = 1'b0;
        endcase
    end

    always_comb begin
        src_val = op_p0[2] ? {27'd0, uimm_p0} : rs1_p0;
        new_val = old_val;
        op_ok   = 1'b1;
        case (op_p0)
            CSR_OP_CSRRW, CSR_OP_CSRRWI: new_val = src_val;
            CSR_OP_CSRRS, CSR_OP_CSRRSI: new_val = old_val | src_val;
            CSR_OP_CSRRC, CSR_OP_CSRRCI: new_val = old_val & ~src_val;
            CSR_OP_NA:                   op_ok   = 1'b0;
            default:                     op_ok   = 1'b0;
        endcase
    end

    assign illegal_c = !known || (we_p0 && read_only) || (!op_ok && (we_p0 || re_p0));
    assign do_write  = (state_q == ST_EXEC) && we_p0 && !illegal_c;
    assign wr_val    = (old_val & ~wr_mask) | (new_val & wr_mask);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mstatus_q  <= MSTATUS_RESET;
            mie_q      <= '0;
            mip_q      <= '0;
            mtvec_q    <= '0;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
        end else if (do_write) begin
            case (addr_p0)
                CSR_MSTATUS:  mstatus_q  <= wr_val;
                CSR_MIE:      mie_q      <= wr_val;
                CSR_MIP:      mip_q      <= wr_val;
                CSR_MTVEC:    mtvec_q    <= wr_val;
                CSR_MSCRATCH: mscratch_q <= wr_val;
                CSR_MEPC:     mepc_q     <= wr_val;
                CSR_MCAUSE:   mcause_q   <= wr_val;
                CSR_MTVAL:    mtval_q    <= wr_val;
                default: ;
            endcase
        end
    end

    csr_counter64 u_mcycle (
        .clk    (clk),
        .resetn (resetn),
        .inc    (1'b1),
        .wr_lo  (do_write && (addr_p0 == CSR_MCYCLE)),
        .wr_hi  (do_write && (addr_p0 == CSR_MCYCLEH)),
        .wdata  (wr_val),
        .value  (mcycle)
    );

    csr_counter64 u_minstret (
        .clk    (clk),
        .resetn (resetn),
        .inc    (instret_inc),
        .wr_lo  (do_write && (addr_p0 == CSR_MINSTRET)),
        .wr_hi  (do_write && (addr_p0 == CSR_MINSTRETH)),
        .wdata  (wr_val),
        .value  (minstret)
    );

    // ---- p1: response capture at the end of EXEC ----
    always_ff @(posedge clk) begin
        if (state_q == ST_EXEC) begin
            rdata_p1   <= (re_p0 && !illegal_c) ? old_val : '0;
            illegal_p1 <= illegal_c;
        end
    end

    assign rdata_valid = (state_q == ST_RESP);
    assign rdata       = rdata_valid ? rdata_p1 : '0;
    assign illegal     = rdata_valid ? illegal_p1 : 1'b0;

endmodule

// File: tb/tb_csr_exec_unit.sv
// Scoreboard bench for csr_exec_unit: each request pushes its expected response,
// which the scenario task pops and compares once the response strobe appears.
import csr_exec_unit_pkg::*;

module tb_csr_exec_unit;

    logic                    clk = 1'b0;
    logic                    resetn = 1'b0;
    logic                    req_valid = 1'b0;
    logic                    req_ready;
    logic                    CSRwe = 1'b0;
    logic                    CSRre = 1'b0;
    logic [CSR_OP_WIDTH-1:0] CSRop = CSR_OP_NA;
    logic [11:0]             csr_addr = '0;
    logic [31:0]             rs1_data = '0;
    logic [4:0]              uimm = '0;
    logic                    instret_inc = 1'b0;
    logic [31:0]             rdata;
    logic                    rdata_valid;
    logic                    illegal;

    typedef struct packed {
        logic [31:0] rdata;
        logic        illegal;
    } exp_t;

    exp_t        sb_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    logic [63:0] tb_cyc;

    csr_exec_unit #(.HART_ID(32'h0000_0003)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .CSRwe       (CSRwe),
        .CSRre       (CSRre),
        .CSRop       (CSRop),
        .csr_addr    (csr_addr),
        .rs1_data    (rs1_data),
        .uimm        (uimm),
        .instret_inc (instret_inc),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .illegal     (illegal)
    );

    always #5 clk = ~clk;

    // Reference cycle count: edges seen since reset release.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) tb_cyc <= '0;
        else         tb_cyc <= tb_cyc + 64'd1;
    end

    task automatic send(input logic [2:0] op, input logic we, input logic re,
                        input logic [11:0] addr, input logic [31:0] rs1, input logic [4:0] imm,
                        input logic [31:0] exp_rd, input logic exp_il, input logic cyc_rel,
                        output logic [63:0] acc_cyc);
        exp_t e;
        @(negedge clk);
        for (int i = 0; i < 8 && !req_ready; i++) @(negedge clk);
        req_valid = 1'b1; CSRop = op; CSRwe = we; CSRre = re;
        csr_addr = addr; rs1_data = rs1; uimm = imm;
        @(posedge clk); #1;
        acc_cyc = tb_cyc;
        // Junk on the request inputs while not valid must be ignored.
        req_valid = 1'b0; CSRop = CSR_OP_CSRRW; CSRwe = 1'b1; CSRre = 1'b1;
        csr_addr = CSR_MSCRATCH; rs1_data = $urandom; uimm = 5'h1F;
        e.rdata   = cyc_rel ? (exp_rd + tb_cyc[31:0]) : exp_rd;
        e.illegal = exp_il;
        sb_q.push_back(e);
    endtask

    task automatic get_resp(output logic [31:0] rd, output logic il, output int lat);
        rd = 'x; il = 1'bx; lat = 1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            instret_inc = 1'b0;
            lat++;
            if (rdata_valid) begin
                rd = rdata; il = illegal;
                break;
            end
        end
    endtask

    task automatic test_reset();
        exp_t e; logic [31:0] rd; logic il; int lat; logic [63:0] acc;
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (req_ready !== 1'b1 || rdata_valid !== 1'b0 || rdata !== 32'h0 || illegal !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: ready=%b valid=%b rdata=%h illegal=%b, expected 1 0 00000000 0",
                     req_ready, rdata_valid, rdata, illegal);
        end
        @(negedge clk); resetn = 1'b1;
        send(CSR_OP_CSRRS, 1'b0, 1'b1, CSR_MSTATUS, 32'h0, 5'h0, 32'h0000_1800, 1'b0, 1'b0, acc);
        get_resp(rd, il, lat); e = sb_q.pop_front(); vectors++;
        if (rd !== e.rdata || il !== e.illegal) begin miscompares++;
            $display("FAIL reset_mstatus: rdata=%h illegal=%b, expected %h %b", rd, il, e.rdata, e.illegal); end
        send(CSR_OP_CSRRS, 1'b0, 1'b1, CSR_MSCRATCH, 32'h0, 5'h0, 32'h0, 1'b0, 1'b0, acc);
        get_resp(rd, il, lat); e = sb_q.pop_front(); vectors++;
        if (rd !== e.rdata || il !== e.illegal) begin miscompares++;
            $display("FAIL reset_mscratch: rdata=%h illegal=%b, expected %h %b", rd, il, e.rdata, e.illegal); end
        send(CSR_OP_CSRRS, 1'b0, 1'b1, CSR_MHARTID, 32'h0, 5'h0, 32'h3, 1'b0, 1'b0, acc);
        get_resp(rd, il, lat); e = sb_q.pop_front(); vectors++;
        if (rd !== e.rdata || il !== e.illegal) begin miscompares++;
            $display("FAIL mhartid: rdata=%h illegal=%b, expected %h %b", rd, il, e.rdata, e.illegal); end
    endtask

    task automatic test_csrrw();
        exp_t e; logic [31:0] rd; logic il; int lat; logic [63:0] acc;
        send(CSR_OP_CSRRW, 1'b1, 1'b0, CSR_MSCRATCH, 32'h1234_5678, 5'h0, 32'h0, 1'b0, 1'b0, acc);
        get_resp(rd, il, lat); e = sb_q.pop_front(); vectors++;
        if (rd !== e.rdata || il !== e.illegal) begin miscompares++;
            $display("FAIL csrrw_noread: rdata=%h illegal=%b, expected %h %b", rd, il, e.rdata, e.illegal); end
        send(CSR_OP_CSRRW, 1'b1, 1'b1, CSR_MSCRATCH, 32'hDEAD_BEEF, 5'h0, 32'h1234_5678, 1'b0, 1'b0, acc);
        get_resp(rd, il, lat); e = sb_q.pop_front(); vectors++;
        if (rd !== e.rdata || il !== e.illegal) begin miscompares++;
            $display("FAIL csrrw_old: rdata=%h illegal=%b, expected %h %b", rd, il, e.rdata, e.illegal); end
        vectors++;
        if (lat !== 2) begin miscompares++;
            $display("FAIL csrrw_latency: %0d cycles, expected 2", lat); end
        @(posedge clk); #1;
        vectors++;
        if (rdata_valid !== 1'b0 || req_ready !== 1'b1) begin miscompares++;
            $display("FAIL strobe_width: valid=%b ready=%b, expected 0 1", rdata_valid, req_ready); end
        send(CSR_OP_CSRRS, 1'b0, 1'b1, CSR_MSCRATCH, 32'h0, 5'h0, 32'hDEAD_BEEF, 1'b0, 1'b0, acc);
        get_resp(rd, il, lat); e = sb_q.pop_front(); vectors++;
        if (rd !== e.rdata || il !== e.illegal) begin miscompares++;
            $display("FAIL csrrw_new: rdata=%h illegal=%b, expected %h %b", rd, il, e.rdata, e.illegal); end
    endtask

    task automatic test_set_clear();
        exp_t e; logic [31:0] rd; logic il; int lat; logic [63:0] acc;
        send(CSR_OP_CSRRSI, 1'b1, 1'b1, CSR_MSTATUS, 32'h0, 5'h08, 32'h0000_1800, 1'b0, 1'b0, acc);
        get_resp(rd, il, lat); e = sb_q.pop_front(); vectors++;
        if (rd !== e.rdata || il !== e.illegal) begin miscompares++;
            $display("FAIL csrrsi_old: rdata=%h illegal=%b, expected %h %b", rd, il, e.rdata, e.illegal); end
        send(CSR_OP_CSRRS, 1'b0, 1'b1, CSR_MSTATUS, 32'h0, 5'h0, 32'h0000_1808, 1'b0, 1'b0, acc);
        get_resp(rd, il, lat); e = sb_q.pop_front(); vectors++;
        if (rd !== e.rdata || il !== e.illegal) begin miscompares++;
            $display("FAIL csrrsi_new: rdata=%h illegal=%b, expected %h %b", rd, il, e.rdata, e.illegal); end
        send(CSR_OP_CSRRW, 1'b1, 1'b0, CSR_MIE, 32'h0000_0888, 5'h0, 32'h0, 1'b0, 1'b0, acc);
        get_resp(rd, il, lat); void'(sb_q.pop_front());
        send(CSR_OP_CSRRC, 1'b1, 1'b1, CSR_MIE, 32'hFFFF_FFFF, 5'h0, 32'h0000_0888, 1'b0, 1'b0, acc);
        get_resp(rd, il, lat); e = sb_q.pop_front(); vectors++;
        if (rd !== e.rdata || il !== e.illegal) begin miscompares++;
            $display("FAIL csrrc_old: rdata=%h illegal=%b, expected %h %b", rd, il, e.rdata, e.illegal); end
        send(CSR_OP_CSRRS, 1'b0, 1'b1, CSR_MIE, 32'h0, 5'h0, 32'h0, 1'b0, 1'b0, acc);
        get_resp(rd, il, lat); e = sb_q.pop_front(); vectors++;
        if (rd !== e.rdata || il !== e.illegal) begin miscompares++;
            $display("FAIL csrrc_new: rdata=%h illegal=%b, expected %h %b", rd, il, e.rdata, e.illegal); end
    endtask

    task automatic test_masks();
        exp_t e; logic [31:0] rd; logic il; int lat; logic [63:0] acc;
        send(CSR_OP_CSRRW, 1'b1, 1'b0, CSR_MTVEC, 32'hFFFF_FFFF, 5'h0, 32'h0, 1'b0, 1'b0, acc);
        get_resp(rd, il, lat); void'(sb_q.pop_front());
        send(CSR_OP_CSRRS, 1'b0, 1'b1, CSR_MTVEC, 32'h0, 5'h0, 32'hFFFF_FFFC, 1'b0, 1'b0, acc);
        get_resp(rd, il, lat); e = sb_q.pop_front(); vectors++;
        if (rd !== e.rdata || il !== e.illegal) begin miscompares++;
            $display("FAIL mtvec_mask: rdata=%h illegal=%b, expected %h %b", rd, il, e.rdata, e.illegal); end
        send(CSR_OP_CSRRW, 1'b1, 1'b0, CSR_MEPC, 32'hFFFF_FFFF, 5'h0, 32'h0, 1'b0, 1'b0, acc);
        get_resp(rd, il, lat); void'(sb_q.pop_front());
        send(CSR_OP_CSRRCI, 1'b1, 1'b1, CSR_MEPC, 32'h0, 5'h10, 32'hFFFF_FFFE, 1'b0, 1'b0, acc);
        get_resp(rd, il, lat); e = sb_q.pop_front(); vectors++;
        if (rd !== e.rdata || il !== e.illegal) begin miscompares++;
            $display("FAIL mepc_mask: rdata=%h illegal=%b, expected %h %b", rd, il, e.rdata, e.illegal); end
        send(CSR_OP_CSRRS, 1'b0, 1'b1, CSR_MEPC, 32'h0, 5'h0, 32'hFFFF_FFEE, 1'b0, 1'b0, acc);
        get_resp(rd, il, lat); e = sb_q.pop_front(); vectors++;
        if (rd !== e.rdata || il !== e.illegal) begin miscompares++;
            $display("FAIL csrrci_new: rdata=%h illegal=%b, expected %h %b", rd, il, e.rdata, e.illegal); end
    endtask

    task automatic test_illegal();
        exp_t e; logic [31:0] rd; logic il; int lat; logic [63:0] acc_w, acc;
        send(CSR_OP_CSRRW, 1'b1, 1'b0, CSR_MCYCLE, 32'h0000_0100, 5'h0, 32'h0, 1'b0, 1'b0, acc_w);
        get_resp(rd, il, lat); void'(sb_q.pop_front());
        send(CSR_OP_CSRRW, 1'b1, 1'b1, CSR_CYCLE, 32'h0, 5'h0, 32'h0, 1'b1, 1'b0, acc);
        get_resp(rd, il, lat); e = sb_q.pop_front(); vectors++;
        if (rd !== e.rdata || il !== e.illegal) begin miscompares++;
            $display("FAIL ro_write: rdata=%h illegal=%b, expected %h %b", rd, il, e.rdata, e.illegal); end
        // Written value plus edges elapsed since the write landed (one edge after acceptance).
        send(CSR_OP_CSRRS, 1'b0, 1'b1, CSR_CYCLE, 32'h0, 5'h0, 32'h100 - acc_w[31:0] - 32'd1, 1'b0, 1'b1, acc);
        get_resp(rd, il, lat); e = sb_q.pop_front(); vectors++;
        if (rd !== e.rdata || il !== e.illegal) begin miscompares++;
            $display("FAIL cycle_after_write: rdata=%h illegal=%b, expected %h %b", rd, il, e.rdata, e.illegal); end
        send(CSR_OP_CSRRS, 1'b0, 1'b1, CSR_TIME, 32'h0, 5'h0, 32'h100 - acc_w[31:0] - 32'd1, 1'b0, 1'b1, acc);
        get_resp(rd, il, lat); e = sb_q.pop_front(); vectors++;
        if (rd !== e.rdata || il !== e.illegal) begin miscompares++;
            $display("FAIL time_alias: rdata=%h illegal=%b, expected %h %b", rd, il, e.rdata, e.illegal); end
        send(CSR_OP_CSRRS, 1'b0, 1'b1, CSR_CYCLEH, 32'h0, 5'h0, 32'h0, 1'b0, 1'b0, acc);
        get_resp(rd, il, lat); e = sb_q.pop_front(); vectors++;
        if (rd !== e.rdata || il !== e.illegal) begin miscompares++;
            $display("FAIL cycleh: rdata=%h illegal=%b, expected %h %b", rd, il, e.rdata, e.illegal); end
        send(CSR_OP_CSRRS, 1'b0, 1'b1, 12'h7C0, 32'h0, 5'h0, 32'h0, 1'b1, 1'b0, acc);
        get_resp(rd, il, lat); e = sb_q.pop_front(); vectors++;
        if (rd !== e.rdata || il !== e.illegal) begin miscompares++;
            $display("FAIL unlisted_addr: rdata=%h illegal=%b, expected %h %b", rd, il, e.rdata, e.illegal); end
        send(CSR_OP_NA, 1'b0, 1'b1, CSR_MSTATUS, 32'h0, 5'h0, 32'h0, 1'b1, 1'b0, acc);
        get_resp(rd, il, lat); e = sb_q.pop_front(); vectors++;
        if (rd !== e.rdata || il !== e.illegal) begin miscompares++;
            $display("FAIL na_op: rdata=%h illegal=%b, expected %h %b", rd, il, e.rdata, e.illegal); end
        send(CSR_OP_CSRRW, 1'b1, 1'b1, CSR_MHARTID, 32'h55, 5'h0, 32'h0, 1'b1, 1'b0, acc);
        get_resp(rd, il, lat); e = sb_q.pop_front(); vectors++;
        if (rd !== e.rdata || il !== e.illegal) begin miscompares++;
            $display("FAIL mhartid_write: rdata=%h illegal=%b, expected %h %b", rd, il, e.rdata, e.illegal); end
    endtask

    task automatic test_minstret();
        exp_t e; logic [31:0] rd; logic il; int lat; logic [63:0] acc;
        send(CSR_OP_CSRRW, 1'b1, 1'b0, CSR_MINSTRET, 32'hFFFF_FFFF, 5'h0, 32'h0, 1'b0, 1'b0, acc);
        get_resp(rd, il, lat); void'(sb_q.pop_front());
        // Retire pulse lands on the same edge as the minstreth write.
        send(CSR_OP_CSRRW, 1'b1, 1'b0, CSR_MINSTRETH, 32'h5, 5'h0, 32'h0, 1'b0, 1'b0, acc);
        instret_inc = 1'b1;
        get_resp(rd, il, lat); void'(sb_q.pop_front());
        send(CSR_OP_CSRRS, 1'b0, 1'b1, CSR_INSTRET, 32'h0, 5'h0, 32'hFFFF_FFFF, 1'b0, 1'b0, acc);
        get_resp(rd, il, lat); e = sb_q.pop_front(); vectors++;
        if (rd !== e.rdata || il !== e.illegal) begin miscompares++;
            $display("FAIL coincident_lo: rdata=%h illegal=%b, expected %h %b", rd, il, e.rdata, e.illegal); end
        send(CSR_OP_CSRRS, 1'b0, 1'b1, CSR_MINSTRETH, 32'h0, 5'h0, 32'h5, 1'b0, 1'b0, acc);
        get_resp(rd, il, lat); e = sb_q.pop_front(); vectors++;
        if (rd !== e.rdata || il !== e.illegal) begin miscompares++;
            $display("FAIL coincident_hi: rdata=%h illegal=%b, expected %h %b", rd, il, e.rdata, e.illegal); end
        @(negedge clk); instret_inc = 1'b1;
        @(negedge clk); instret_inc = 1'b0;
        send(CSR_OP_CSRRS, 1'b0, 1'b1, CSR_MINSTRET, 32'h0, 5'h0, 32'h0, 1'b0, 1'b0, acc);
        get_resp(rd, il, lat); e = sb_q.pop_front(); vectors++;
        if (rd !== e.rdata || il !== e.illegal) begin miscompares++;
            $display("FAIL minstret_wrap: rdata=%h illegal=%b, expected %h %b", rd, il, e.rdata, e.illegal); end
        send(CSR_OP_CSRRS, 1'b0, 1'b1, CSR_INSTRETH, 32'h0, 5'h0, 32'h6, 1'b0, 1'b0, acc);
        get_resp(rd, il, lat); e = sb_q.pop_front(); vectors++;
        if (rd !== e.rdata || il !== e.illegal) begin miscompares++;
            $display("FAIL minstreth_carry: rdata=%h illegal=%b, expected %h %b", rd, il, e.rdata, e.illegal); end
    endtask

    task automatic test_reset_abort();
        exp_t e; logic [31:0] rd; logic il; int lat; logic [63:0] acc; logic strobe_seen;
        send(CSR_OP_CSRRW, 1'b1, 1'b1, CSR_MSCRATCH, 32'hA5A5_A5A5, 5'h0, 32'h0, 1'b0, 1'b0, acc);
        void'(sb_q.pop_back());
        resetn = 1'b0;
        #1;
        vectors++;
        if (rdata_valid !== 1'b0 || req_ready !== 1'b1) begin miscompares++;
            $display("FAIL abort_in_reset: valid=%b ready=%b, expected 0 1", rdata_valid, req_ready); end
        strobe_seen = 1'b0;
        repeat (2) begin @(posedge clk); #1; if (rdata_valid) strobe_seen = 1'b1; end
        @(negedge clk); resetn = 1'b1;
        repeat (3) begin @(posedge clk); #1; if (rdata_valid) strobe_seen = 1'b1; end
        vectors++;
        if (strobe_seen !== 1'b0) begin miscompares++;
            $display("FAIL abort_strobe: saw rdata_valid=%b, expected 0", strobe_seen); end
        vectors++;
        if (req_ready !== 1'b1) begin miscompares++;
            $display("FAIL abort_ready: req_ready=%b, expected 1", req_ready); end
        send(CSR_OP_CSRRS, 1'b0, 1'b1, CSR_MSCRATCH, 32'h0, 5'h0, 32'h0, 1'b0, 1'b0, acc);
        get_resp(rd, il, lat); e = sb_q.pop_front(); vectors++;
        if (rd !== e.rdata || il !== e.illegal) begin miscompares++;
            $display("FAIL abort_mscratch: rdata=%h illegal=%b, expected %h %b", rd, il, e.rdata, e.illegal); end
    endtask

    initial begin
        test_reset();
        test_csrrw();
        test_set_clear();
        test_masks();
        test_illegal();
        test_minstret();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule
